// File: rtl/vec_pkg.sv
// Shared types and constants for the packed-vector lane sequencer.
// The lane saturation option (VEC_SAT_EN) lives only in vec_lane_fix.
package vec_pkg;

  localparam int DEF_DATA_W = 32;
  localparam int DEF_LANE_W = 8;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/vec_lane_fix.sv
// Turns one lane's {carry/borrow, value} from the shared ALU into the final lane value.
// VEC_SAT_EN defined: unsigned saturation per lane; undefined: wrap modulo 2^LANE_W.
module vec_lane_fix #(
  parameter int LANE_W = 8
) (
  input  logic [LANE_W:0]   sum,
  input  logic              op_sub,
  output logic [LANE_W-1:0] lane_out
);

`ifdef VEC_SAT_EN
  // The top bit is carry for add and borrow for sub; clamp toward the overflowed side.
  always_comb begin
    lane_out = sum[LANE_W-1:0];
    if (sum[LANE_W]) begin
      lane_out = op_sub ? '0 : '1;
    end
  end
`else
  logic unused_fix;

  assign unused_fix = ^{sum[LANE_W], op_sub};
  assign lane_out   = sum[LANE_W-1:0];
`endif

endmodule

// File: rtl/vec_lane_sequencer.sv
// Multicycle packed-vector add/sub controller: stalls fetch, streams one lane per cycle
// through the shared ALU and issues a single register write. Option: VEC_SAT_EN (in vec_lane_fix).
module vec_lane_sequencer
  import vec_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int LANE_W = DEF_LANE_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              op_sub,
  input  logic [DATA_W-1:0] srca,
  input  logic [DATA_W-1:0] srcb,
  output logic              alu_sel,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  output logic [2:0]        alu_ctrl,
  input  logic [DATA_W-1:0] alu_result,
  output logic              stall,
  output logic              busy,
  output logic [DATA_W-1:0] result,
  output logic              result_valid,
  output logic              reg_we
);

  localparam int LANES = DATA_W / LANE_W;
  localparam int CNT_W = (LANES > 1) ? $clog2(LANES) : 1;
  localparam logic [CNT_W-1:0] LAST_LANE = CNT_W'(LANES - 1);

  generate
    if (DATA_W % LANE_W != 0) begin : g_bad_width
      $error("vec_lane_sequencer: DATA_W must be a multiple of LANE_W");
    end
  endgenerate

  state_t             state;
  logic [CNT_W-1:0]   lane;
  logic [DATA_W-1:0]  a_q;
  logic [DATA_W-1:0]  b_q;
  logic [DATA_W-1:0]  res_q;
  logic               sub_q;
  logic               valid_q;
  logic [LANE_W-1:0]  lane_a;
  logic [LANE_W-1:0]  lane_b;
  logic [LANE_W-1:0]  lane_fix;
  logic               in_run;
  logic               unused_alu;

  assign lane_a     = a_q[int'(lane)*LANE_W +: LANE_W];
  assign lane_b     = b_q[int'(lane)*LANE_W +: LANE_W];
  assign unused_alu = ^alu_result;

  vec_lane_fix #(
    .LANE_W (LANE_W)
  ) u_fix (
    .sum      (alu_result[LANE_W:0]),
    .op_sub   (sub_q),
    .lane_out (lane_fix)
  );

  // Operands are captured only on an accepted start, so later starts cannot disturb a running op.
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      lane    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      sub_q   <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          valid_q <= 1'b0;
          if (start) begin
            a_q   <= srca;
            b_q   <= srcb;
            sub_q <= op_sub;
            lane  <= '0;
            state <= RUN;
          end
        end
        RUN: begin
          res_q[int'(lane)*LANE_W +: LANE_W] <= lane_fix;
          if (lane == LAST_LANE) begin
            valid_q <= 1'b1;
            state   <= DONE;
          end else begin
            lane <= lane + 1'b1;
          end
        end
        DONE: begin
          valid_q <= 1'b0;
          state   <= IDLE;
        end
        default: begin
          valid_q <= 1'b0;
          state   <= IDLE;
        end
      endcase
    end
  end

  // Zero-extending each lane keeps carries and borrows from leaking between lanes.
  assign in_run       = (state == RUN);
  assign alu_sel      = in_run;
  assign alu_a        = in_run ? DATA_W'(lane_a) : '0;
  assign alu_b        = in_run ? DATA_W'(lane_b) : '0;
  assign alu_ctrl     = (in_run && sub_q) ? ALU_SUB : ALU_ADD;
  assign stall        = ((state == IDLE) && start) || in_run;
  assign busy         = (state != IDLE);
  assign result       = res_q;
  assign result_valid = valid_q;
  assign reg_we       = valid_q;

endmodule

// File: tb/tb_vec_lane_sequencer.sv
// Self-checking bench for vec_lane_sequencer: directed cases plus randomized traffic against
// a cycle-numbered reference model. Honors VEC_SAT_EN the same way as the design.
module tb_vec_lane_sequencer;

  localparam int LANES = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic        op_sub;
  logic [31:0] srca;
  logic [31:0] srcb;
  logic        alu_sel;
  logic [31:0] alu_a;
  logic [31:0] alu_b;
  logic [2:0]  alu_ctrl;
  logic [31:0] alu_result;
  logic        stall;
  logic        busy;
  logic [31:0] result;
  logic        result_valid;
  logic        reg_we;

  always #5 clk = ~clk;

  vec_lane_sequencer dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .op_sub       (op_sub),
    .srca         (srca),
    .srcb         (srcb),
    .alu_sel      (alu_sel),
    .alu_a        (alu_a),
    .alu_b        (alu_b),
    .alu_ctrl     (alu_ctrl),
    .alu_result   (alu_result),
    .stall        (stall),
    .busy         (busy),
    .result       (result),
    .result_valid (result_valid),
    .reg_we       (reg_we)
  );

  // Shared datapath ALU: full 32-bit add or subtract.
  always_comb alu_result = (alu_ctrl == 3'b001) ? (alu_a - alu_b) : (alu_a + alu_b);

  int          checks = 0;
  int          fails  = 0;
  int          cyc    = 0;
  int          opStart = -100;
  logic [31:0] mA, mB, expRes, lastResult;
  logic        mSub;
  int          weCount = 0;
  int          weBefore;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Lane-wise arithmetic straight from the operation's definition.
  function automatic logic [31:0] refResult(input logic [31:0] a, input logic [31:0] b,
                                            input logic sub);
    logic [31:0] r = '0;
    for (int i = 0; i < LANES; i++) begin
      int la = int'((a >> (8 * i)) & 32'hFF);
      int lb = int'((b >> (8 * i)) & 32'hFF);
      int v  = sub ? (la - lb) : (la + lb);
`ifdef VEC_SAT_EN
      if (v < 0)   v = 0;
      if (v > 255) v = 255;
`else
      v = v & 255;
`endif
      r[8*i +: 8] = 8'(v);
    end
    return r;
  endfunction

  task automatic applyStimulus(input logic rst, input logic st, input logic sub,
                               input logic [31:0] a, input logic [31:0] b, input bit doCheck);
    bit active, runPh, doneC;
    int laneIdx;
    reset  = rst;
    start  = st;
    op_sub = sub;
    srca   = a;
    srcb   = b;
    active  = (cyc >= opStart + 1) && (cyc <= opStart + LANES + 1);
    runPh   = (cyc >= opStart + 1) && (cyc <= opStart + LANES);
    doneC   = (cyc == opStart + LANES + 1);
    laneIdx = cyc - opStart - 1;
    @(negedge clk);
    if (doCheck) begin
      checkOutput("busy", 32'(busy), 32'(active));
      checkOutput("stall", 32'(stall), 32'((!active && st) || runPh));
      checkOutput("alu_sel", 32'(alu_sel), 32'(runPh));
      checkOutput("result_valid", 32'(result_valid), 32'(doneC));
      checkOutput("reg_we", 32'(reg_we), 32'(doneC));
      if (runPh) begin
        checkOutput("alu_a", alu_a, (mA >> (8 * laneIdx)) & 32'hFF);
        checkOutput("alu_b", alu_b, (mB >> (8 * laneIdx)) & 32'hFF);
        checkOutput("alu_ctrl", 32'(alu_ctrl), mSub ? 32'd1 : 32'd0);
      end else begin
        checkOutput("alu_a_idle", alu_a, 32'h0);
        checkOutput("alu_b_idle", alu_b, 32'h0);
        checkOutput("alu_ctrl_idle", 32'(alu_ctrl), 32'h0);
      end
      if (doneC) checkOutput("result", result, expRes);
    end
    if (reg_we === 1'b1) begin
      weCount++;
      lastResult = result;
    end
    @(posedge clk);
    #1;
    if (rst) begin
      opStart = -100;
    end else if (!active && st) begin
      opStart = cyc;
      mA      = a;
      mB      = b;
      mSub    = sub;
      expRes  = refResult(a, b, sub);
    end
    cyc++;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, 1'b0, 1'b0, $urandom, $urandom, 1'b1);
  endtask

  task automatic issue(input logic sub, input logic [31:0] a, input logic [31:0] b);
    applyStimulus(1'b0, 1'b1, sub, a, b, 1'b1);
  endtask

  initial begin
    applyStimulus(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
    applyStimulus(1'b1, 1'b1, 1'b1, 32'hFFFF_FFFF, 32'h1, 1'b1);
    checkOutput("reset_result", result, 32'h0);
    checkOutput("reset_ctrl", 32'(alu_ctrl), 32'h0);
    idle(1);

    // Case 1 and plain timing
    weBefore = weCount;
    issue(1'b0, 32'h0102_0304, 32'h1020_3040);
    idle(6);
    checkOutput("case1_value", lastResult, 32'h1122_3344);
    checkOutput("case1_we_count", 32'(weCount - weBefore), 32'd1);

    // Case 2: per-lane overflow
    issue(1'b0, 32'h00FF_00FF, 32'h0001_0001);
    idle(6);
`ifdef VEC_SAT_EN
    checkOutput("case2_value", lastResult, 32'h00FF_00FF);
`else
    checkOutput("case2_value", lastResult, 32'h0000_0000);
`endif

    // Case 3: per-lane borrow
    issue(1'b1, 32'h0505_0505, 32'h0701_0701);
    idle(6);
`ifdef VEC_SAT_EN
    checkOutput("case3_value", lastResult, 32'h0004_0004);
`else
    checkOutput("case3_value", lastResult, 32'hFE04_FE04);
`endif

    // Case 4: starts while busy are ignored
    weBefore = weCount;
    issue(1'b0, 32'h0102_0304, 32'h1020_3040);
    idle(1);
    issue(1'b1, 32'hDEAD_BEEF, 32'h1234_5678);
    issue(1'b1, 32'hCAFE_F00D, 32'h8765_4321);
    idle(4);
    checkOutput("case4_value", lastResult, 32'h1122_3344);
    checkOutput("case4_we_count", 32'(weCount - weBefore), 32'd1);

    // Case 5: reset mid-operation drops the write
    weBefore = weCount;
    issue(1'b0, 32'h1111_1111, 32'h2222_2222);
    idle(2);
    applyStimulus(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1);
    idle(4);
    checkOutput("case5_no_we", 32'(weCount - weBefore), 32'd0);
    issue(1'b1, 32'h8040_2010, 32'h0102_0304);
    idle(6);
    checkOutput("case5_restart", lastResult, refResult(32'h8040_2010, 32'h0102_0304, 1'b1));

    // Case 6: start in DONE is unseen; start in the following IDLE cycle runs back-to-back
    weBefore = weCount;
    issue(1'b0, 32'h0A0B_0C0D, 32'h0101_0101);
    idle(4);
    issue(1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    issue(1'b1, 32'h3030_3030, 32'h4010_2005);
    idle(6);
    checkOutput("case6_we_count", 32'(weCount - weBefore), 32'd2);
    checkOutput("case6_second", lastResult, refResult(32'h3030_3030, 32'h4010_2005, 1'b1));

    // Randomized traffic with occasional resets and edge-heavy operands
    for (int i = 0; i < 400; i++) begin
      logic [31:0] ra, rb;
      ra = ($urandom_range(0, 3) == 0) ? 32'hFF00_FF80 ^ $urandom_range(0, 255) : $urandom;
      rb = ($urandom_range(0, 3) == 0) ? 32'h0101_80FF : $urandom;
      applyStimulus(($urandom_range(0, 59) == 0), ($urandom_range(0, 2) == 0),
                    1'($urandom_range(0, 1)), ra, rb, 1'b1);
    end
    idle(6);

    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end

endmodule
